// File: rtl/glitcbus_decoder_v3_if.sv
// GLITCBUS local-side user bus between the slave core and the address decoder.
// The core side drives requests (master); the decoder answers them (slave).
interface glitcbus_decoder_v3_if;
   logic [15:0] user_addr_i;
   logic [31:0] user_dat_i;
   logic        user_wr_i;
   logic        user_rd_i;
   logic [31:0] user_dat_o;
   logic        user_ack_o;
   logic        user_err_o;

   modport master (
      output user_addr_i, user_dat_i, user_wr_i, user_rd_i,
      input  user_dat_o, user_ack_o, user_err_o
   );

   modport slave (
      input  user_addr_i, user_dat_i, user_wr_i, user_rd_i,
      output user_dat_o, user_ack_o, user_err_o
   );
endinterface

// File: rtl/glitcbus_decoder_v3.sv
// GLITCBUS address decoder and read-return mux. Each request is sequenced through
// ACCESS/WAIT so that slow or absent slaves end in a timeout error, not a hang.
module glitcbus_decoder_v3 #(
   parameter int          NSLAVES    = 8,
   parameter int          SEL_LSB    = 4,
   parameter int          SEL_W      = 4,
   parameter int          SAMPLE_BIT = 13,
   parameter int          TIMEOUT    = 15,
   parameter logic [31:0] ERR_DATA   = 32'hBADACCE5
) (
   input  logic                   user_clk_i,
   input  logic                   user_rst_n_i,
   glitcbus_decoder_v3_if.slave   bus,
   output logic [7:0]             err_count_o,
   output logic [NSLAVES-1:0]     slv_sel_o,
   output logic                   smp_sel_o,
   output logic                   slv_wr_o,
   output logic                   slv_rd_o,
   output logic [15:0]            slv_addr_o,
   output logic [31:0]            slv_dat_o,
   input  logic [32*NSLAVES-1:0]  slv_dat_i,
   input  logic [NSLAVES-1:0]     slv_ack_i,
   input  logic [31:0]            smp_dat_i,
   input  logic                   smp_ack_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

   state_e             state_q, state_d;
   logic               done_err;
   logic [15:0]        addr_q;
   logic [31:0]        wdat_q, rdata_q;
   logic               wr_q, smp_q, err_q;
   logic [SEL_W-1:0]   idx_q, req_idx;
   logic [7:0]         cnt_q, err_cnt_q;
   logic               req_one, req_both, req_smp, req_mapped;
   logic               tgt_ack, drop, busy;
   logic [31:0]        tgt_dat;
   logic [1:0]         err_inc;
   logic [8:0]         err_sum;

   assign req_both   = bus.user_wr_i & bus.user_rd_i;
   assign req_one    = bus.user_wr_i ^ bus.user_rd_i;
   assign req_smp    = bus.user_addr_i[SAMPLE_BIT];
   assign req_idx    = bus.user_addr_i[SEL_LSB +: SEL_W];
   assign req_mapped = 32'(req_idx) < 32'(NSLAVES);
   assign busy       = (state_q == ACCESS) || (state_q == WAIT);

   // Only the latched target may complete the transaction; other acks are ignored.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      tgt_ack = smp_ack_i;
      tgt_dat = smp_dat_i;
      if (!smp_q) begin
         tgt_ack = 1'b0;
         tgt_dat = '0;
         for (int k = 0; k < NSLAVES; k++) begin
            if (idx_q == SEL_W'(k)) begin
               tgt_ack = slv_ack_i[k];
               tgt_dat = slv_dat_i[32*k +: 32];
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      done_err = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_both) begin
               state_d  = DONE;
               done_err = 1'b1;
            end else if (req_one) begin
               if (req_smp || req_mapped) begin
                  state_d = ACCESS;
               end else begin
                  state_d  = DONE;
                  done_err = 1'b1;
               end
            end
         end
         ACCESS: state_d = tgt_ack ? DONE : WAIT;
         WAIT: begin
            if (tgt_ack) begin
               state_d = DONE;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
               state_d  = DONE;
               done_err = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A strobe outside IDLE and a failing completion can coincide: both are counted.
   assign drop    = (state_q != IDLE) && (bus.user_wr_i || bus.user_rd_i);
   assign err_inc = {1'b0, drop} + {1'b0, done_err};
   assign err_sum = {1'b0, err_cnt_q} + {7'b0, err_inc};

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
      if (!user_rst_n_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdat_q    <= '0;
         rdata_q   <= '0;
         wr_q      <= 1'b0;
         smp_q     <= 1'b0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_one) begin
            addr_q <= bus.user_addr_i;
            wdat_q <= bus.user_dat_i;
            wr_q   <= bus.user_wr_i;
            smp_q  <= req_smp;
            idx_q  <= req_idx;
         end
         if (state_d == DONE) err_q <= done_err;
         cnt_q <= (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
         if (done_err) begin
            rdata_q <= ERR_DATA;
         end else if (busy && tgt_ack && !wr_q) begin
            rdata_q <= tgt_dat;
         end
         err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
      end
   end

   always_comb begin
      slv_sel_o = '0;
      for (int k = 0; k < NSLAVES; k++) begin
         slv_sel_o[k] = busy && !smp_q && (idx_q == SEL_W'(k));
      end
      smp_sel_o      = busy && smp_q;
      slv_wr_o       = (state_q == ACCESS) && wr_q;
      slv_rd_o       = (state_q == ACCESS) && !wr_q;
      bus.user_ack_o = (state_q == DONE);
      bus.user_err_o = (state_q == DONE) && err_q;
   end

   assign bus.user_dat_o = rdata_q;
   assign slv_addr_o     = addr_q;
   assign slv_dat_o      = wdat_q;
   assign err_count_o    = err_cnt_q;

endmodule

// File: tb/tb_glitcbus_decoder_v3.sv
// Directed bench for glitcbus_decoder_v3: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever user_ack_o is presented.
module tb_glitcbus_decoder_v3;

   typedef struct {
      int          cyc;
      logic        err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    err_count;
   logic [7:0]    slv_sel;
   logic          smp_sel, slv_wr, slv_rd;
   logic [15:0]   slv_addr;
   logic [31:0]   slv_dat;
   logic [255:0]  slv_dat_bus;
   logic [7:0]    slv_ack;
   logic [31:0]   smp_dat;
   logic          smp_ack;

   int            dly [8];
   int            dly_smp;
   logic [7:0]    stray;
   logic [31:0]   sdata [8];
   int            sel_cycles = 0;
   int            cyc = 0;
   int            n_cmp = 0;
   int            n_fail = 0;
   exp_t          sb [$];
   exp_t          mon_e;

   always #5 clk = ~clk;

   glitcbus_decoder_v3_if bus ();

   glitcbus_decoder_v3 dut (
      .user_clk_i   (clk),
      .user_rst_n_i (rst_n),
      .bus          (bus.slave),
      .err_count_o  (err_count),
      .slv_sel_o    (slv_sel),
      .smp_sel_o    (smp_sel),
      .slv_wr_o     (slv_wr),
      .slv_rd_o     (slv_rd),
      .slv_addr_o   (slv_addr),
      .slv_dat_o    (slv_dat),
      .slv_dat_i    (slv_dat_bus),
      .slv_ack_i    (slv_ack),
      .smp_dat_i    (smp_dat),
      .smp_ack_i    (smp_ack)
   );

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) sel_cycles <= ((|slv_sel) || smp_sel) ? sel_cycles + 1 : 0;

   // Slave model: a selected slave acks once it has been selected for dly[k] cycles.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         slv_ack[k]               = stray[k] | (slv_sel[k] && (dly[k] == sel_cycles));
         slv_dat_bus[32*k +: 32]  = sdata[k];
      end
      smp_ack = smp_sel && (dly_smp == sel_cycles);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.user_ack_o === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            check("ack_err", {31'b0, bus.user_err_o}, {31'b0, mon_e.err});
            if (mon_e.chk) check("ack_data", bus.user_dat_o, mon_e.dat);
         end
      end
   end

   // Drive one request strobe; returns one cycle later with inputs released.
   task automatic issue(input logic w, input logic r, input logic [15:0] a, input logic [31:0] d,
                        input bit push, input int lat, input logic e, input logic cd,
                        input logic [31:0] ed);
      exp_t x;
      @(posedge clk); #1;
      bus.user_wr_i   = w;
      bus.user_rd_i   = r;
      bus.user_addr_i = a;
      bus.user_dat_i  = d;
      if (push) begin
         x = '{cyc: cyc + lat, err: e, chk: cd, dat: ed};
         sb.push_back(x);
      end
      @(posedge clk); #1;
      bus.user_wr_i = 1'b0;
      bus.user_rd_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time budget exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_sel, n_wr;
      for (int k = 0; k < 8; k++) begin
         dly[k]   = -1;
         sdata[k] = 32'h1000_0000 + 32'(k);
      end
      dly_smp         = -1;
      stray           = '0;
      smp_dat         = 32'h5A5A_0000;
      bus.user_wr_i   = 1'b0;
      bus.user_rd_i   = 1'b0;
      bus.user_addr_i = '0;
      bus.user_dat_i  = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ack", {31'b0, bus.user_ack_o}, 32'd0);
      check("rst_err", {31'b0, bus.user_err_o}, 32'd0);
      check("rst_dat", bus.user_dat_o, 32'd0);
      check("rst_sel", {23'b0, smp_sel, slv_sel}, 32'd0);
      check("rst_strobe", {30'b0, slv_wr, slv_rd}, 32'd0);
      check("rst_err_count", {24'b0, err_count}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Read slave 2, acked in ACCESS.
      dly[2]   = 0;
      sdata[2] = 32'h1234_5678;
      issue(1'b0, 1'b1, 16'h0020, 32'h0, 1'b1, 2, 1'b0, 1'b1, 32'h1234_5678);
      check("t1_sel", {24'b0, slv_sel}, 32'h04);
      check("t1_rd", {31'b0, slv_rd}, 32'd1);
      repeat (3) @(posedge clk);

      // Write to sample region, ack after 3 WAIT cycles.
      dly_smp = 3;
      issue(1'b1, 1'b0, 16'h2004, 32'hA5A5_A5A5, 1'b1, 5, 1'b0, 1'b0, 32'h0);
      check("t2_wdat", slv_dat, 32'hA5A5_A5A5);
      check("t2_addr", {16'b0, slv_addr}, 32'h2004);
      n_sel = 0;
      n_wr  = 0;
      for (int i = 0; i < 7; i++) begin
         if (smp_sel) n_sel++;
         if (slv_wr)  n_wr++;
         @(posedge clk); #1;
      end
      check("t2_smp_sel_cycles", 32'(n_sel), 32'd4);
      check("t2_wr_cycles", 32'(n_wr), 32'd1);
      dly_smp = -1;

      // Unmapped slave index 15.
      issue(1'b0, 1'b1, 16'h00F0, 32'h0, 1'b1, 1, 1'b1, 1'b1, 32'hBADA_CCE5);
      check("t3_no_sel", {23'b0, smp_sel, slv_sel}, 32'd0);
      check("t3_err_count", {24'b0, err_count}, 32'd1);
      repeat (2) @(posedge clk);

      // Slave 3 never acks; a stray ack from unselected slave 2 must be ignored.
      stray[2] = 1'b1;
      issue(1'b0, 1'b1, 16'h0030, 32'h0, 1'b1, 17, 1'b1, 1'b1, 32'hBADA_CCE5);
      n_sel = 0;
      for (int i = 0; i < 20; i++) begin
         if (slv_sel[3]) n_sel++;
         @(posedge clk); #1;
      end
      check("t4_sel3_cycles", 32'(n_sel), 32'd16);
      check("t4_err_count", {24'b0, err_count}, 32'd2);
      stray[2] = 1'b0;

      // Read slave 4 (5 WAIT cycles); a strobe during WAIT is dropped.
      dly[4]   = 5;
      sdata[4] = 32'hCAFE_F00D;
      issue(1'b0, 1'b1, 16'h0040, 32'h0, 1'b1, 7, 1'b0, 1'b1, 32'hCAFE_F00D);
      @(posedge clk); #1;
      bus.user_rd_i   = 1'b1;
      bus.user_addr_i = 16'h0020;
      @(posedge clk); #1;
      bus.user_rd_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("t5_err_count", {24'b0, err_count}, 32'd3);

      // wr and rd together: immediate error, no strobe.
      issue(1'b1, 1'b1, 16'h0020, 32'h0, 1'b1, 1, 1'b1, 1'b1, 32'hBADA_CCE5);
      check("t6_no_strobe", {29'b0, slv_wr, slv_rd, |slv_sel}, 32'd0);
      check("t6_err_count", {24'b0, err_count}, 32'd4);
      repeat (2) @(posedge clk);

      // Back-to-back reads: second accepted in the IDLE cycle after DONE.
      dly[5]   = 1;
      sdata[5] = 32'h5555_AAAA;
      issue(1'b0, 1'b1, 16'h0020, 32'h0, 1'b1, 2, 1'b0, 1'b1, 32'h1234_5678);
      @(posedge clk); #1;
      issue(1'b0, 1'b1, 16'h0050, 32'h0, 1'b1, 3, 1'b0, 1'b1, 32'h5555_AAAA);
      repeat (5) @(posedge clk);

      // Reset during WAIT aborts with no ack; next request completes normally.
      issue(1'b0, 1'b1, 16'h0030, 32'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      check("t8_sel_before_rst", {24'b0, slv_sel}, 32'h08);
      rst_n = 1'b0;
      #1;
      check("t8_sel_after_rst", {23'b0, smp_sel, slv_sel}, 32'd0);
      check("t8_ack_after_rst", {31'b0, bus.user_ack_o}, 32'd0);
      check("t8_err_count_rst", {24'b0, err_count}, 32'd0);
      check("t8_dat_rst", bus.user_dat_o, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      issue(1'b0, 1'b1, 16'h0020, 32'h0, 1'b1, 2, 1'b0, 1'b1, 32'h1234_5678);
      repeat (3) @(posedge clk);

      // 300 error transactions saturate the error counter.
      for (int i = 0; i < 300; i++) begin
         issue(1'b0, 1'b1, 16'h00F0, 32'h0, 1'b1, 1, 1'b1, 1'b1, 32'hBADA_CCE5);
      end
      repeat (3) @(posedge clk);
      #1;
      check("t9_err_count_sat", {24'b0, err_count}, 32'd255);

      repeat (3) @(posedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/glitcbus_decoder_v3.md
# glitcbus_decoder_v3

Parametrised GLITCBUS local-side address decoder and read-return mux with per-slave acknowledge, timeout and error accounting. It sits between the GLITCBUS slave's local interface and the register sub-blocks (control, phase scanner, datapath, DAC, I2C, intercom, …) plus the sample-storage region. It replaces the fixed 8-way combinational select/mux with a sequenced transaction that tolerates slow or absent slaves.

## Interface
Parameters:
- NSLAVES, 8: number of register-space slaves (1–16).
- SEL_LSB, 4: LSB of the slave-index field in the address.
- SEL_W, 4: width of the slave-index field; indices >= NSLAVES are unmapped.
- SAMPLE_BIT, 13: address bit selecting the sample-storage region.
- TIMEOUT, 15: maximum number of WAIT cycles before abort (1–255).
- ERR_DATA, 32'hBADACCE5: read data returned on error.

Ports:
- user_clk_i in 1: GLITCBUS clock; sole clock.
- user_rst_n_i in 1: asynchronous, active-low reset.
- user_addr_i in 16: request address.
- user_dat_i in 32: write data.
- user_wr_i in 1: write request strobe, 1 cycle.
- user_rd_i in 1: read request strobe, 1 cycle.
- user_dat_o out 32: read data, valid with user_ack_o.
- user_ack_o out 1: transaction-complete pulse.
- user_err_o out 1: error qualifier, valid with user_ack_o.
- err_count_o out 8: saturating error count.
- slv_sel_o out NSLAVES: one-hot register-slave select.
- smp_sel_o out 1: sample-region select.
- slv_wr_o / slv_rd_o out 1 each: slave strobes.
- slv_addr_o out 16: latched address.
- slv_dat_o out 32: latched write data.
- slv_dat_i in 32*NSLAVES: slave read data, slave k at [32k+:32].
- slv_ack_i in NSLAVES: slave acknowledges.
- smp_dat_i in 32 / smp_ack_i in 1: sample-region data and acknowledge.

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE: on wr xor rd, latch addr/data/direction and decode.
  - addr[SAMPLE_BIT]=1 → sample target.
  - Otherwise index = addr[SEL_LSB+:SEL_W].
  - Mapped target → ACCESS. Unmapped target → DONE with error.
- wr and rd asserted together in IDLE → DONE with error; no slave strobe.
- ACCESS (1 cycle): target select high; slv_wr_o or slv_rd_o high for this cycle only. The target's ack seen this cycle → DONE; otherwise → WAIT.
- WAIT: select held, strobes low, timeout counter increments each cycle. Target ack → DONE with no error. Counter reaching TIMEOUT with no ack → DONE with error.
- DONE (1 cycle): user_ack_o=1 and selects low; user_err_o as determined → IDLE.
- Read data is captured from the target's data bus on the ack cycle. On error, ERR_DATA is returned. Writes return the last value on user_dat_o (don't care).
- Acks from non-selected slaves are ignored.
- A request strobe arriving outside IDLE is dropped and counts as one error. user_ack_o is not produced for it.
- err_count_o increments once per error event and saturates at 255. Simultaneous drop and completion errors add 2, saturating.
- slv_addr_o and slv_dat_o hold from ACCESS through DONE.

## Timing
- Reset (async assert, synchronous deassert edge): state IDLE; all outputs 0; err_count_o=0.
- Request sampled at edge N. ACCESS at N+1.
- Ack in ACCESS → user_ack_o at N+2 (minimum latency 2).
- Ack k cycles into WAIT (k=1..) → user_ack_o at N+2+k.
- Timeout → user_ack_o with err at N+2+TIMEOUT.
- Unmapped or conflicting request → user_ack_o with err at N+1.
- Reset mid-transaction aborts immediately: no user_ack_o; selects drop asynchronously.
- Back-to-back: the next request is accepted in the IDLE cycle following DONE.

## Test plan
- Read address 0x0020, slave 2 acks in ACCESS with 0x12345678 → user_ack_o two cycles after rd; user_dat_o=0x12345678; err=0.
- Write 0x2004 with 0xA5A5A5A5; smp_ack_i after 3 WAIT cycles → smp_sel_o high for 4 cycles; slv_wr_o high 1 cycle; slv_dat_o=0xA5A5A5A5; ack at N+5.
- Read 0x00F0 with NSLAVES=8 → ack at N+1; err=1; data 0xBADACCE5; no select; err_count_o=1.
- Read slave 3, never acks, TIMEOUT=15 → ack at N+17; err=1; slv_sel_o[3] high 16 cycles.
- Strobe rd during WAIT of a prior transaction → the second request is dropped; one ack only; err_count_o +1. wr+rd together → immediate error.
- Assert reset during WAIT → outputs 0 immediately; next request completes normally. 300 error transactions → err_count_o holds 255.
